// File: rtl/adf4158_pkg.sv
// Shared types and constants for the ADF4158 configuration sequencer.
// Optional lock wait (macro ADF4158_LOCK_WAIT_EN) is implemented in adf4158_cfg.
package adf4158_pkg;

  localparam int NUM_WORDS  = 11;
  localparam int WORD_WIDTH = 32;
  localparam int IDX_W      = 4;

  // Sequencer states; LOCK_WAIT is only reachable when the lock wait is built in.
  typedef enum logic [2:0] {
    IDLE,
    CE_WAIT,
    SHIFT,
    LATCH,
    LOCK_WAIT,
    DONE
  } state_t;

  // Phases of the serial shifter.
  typedef enum logic [1:0] {
    SH_IDLE,
    SH_SHIFT,
    SH_LATCH
  } sh_phase_t;

  // Register address (control) bits occupying word bits [2:0].
  localparam logic [2:0] CTRL_R0 = 3'd0;
  localparam logic [2:0] CTRL_R1 = 3'd1;
  localparam logic [2:0] CTRL_R2 = 3'd2;
  localparam logic [2:0] CTRL_R3 = 3'd3;
  localparam logic [2:0] CTRL_R4 = 3'd4;
  localparam logic [2:0] CTRL_R5 = 3'd5;
  localparam logic [2:0] CTRL_R6 = 3'd6;
  localparam logic [2:0] CTRL_R7 = 3'd7;

  // Force the address bits of a register word so a mistyped parameter can never
  // land its payload in the wrong register.
  function automatic logic [WORD_WIDTH-1:0] with_ctrl(input logic [WORD_WIDTH-1:0] word,
                                                      input logic [2:0] ctrl);
    return (word & ~{{(WORD_WIDTH-3){1'b0}}, 3'b111}) | {{(WORD_WIDTH-3){1'b0}}, ctrl};
  endfunction

endpackage

// File: rtl/adf4158_shifter.sv
// Serialises one 32-bit word MSB first onto sclk/data, then pulses le.
// sclk is low for the first half of each bit and high for the second half;
// data changes only at the start of the low half. word_done marks the last le cycle
// so the sequencer can start the next word without a gap.
module adf4158_shifter
  import adf4158_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int LE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word,
  output logic                  sclk,
  output logic                  data,
  output logic                  le,
  output logic                  shift_end,
  output logic                  word_done
);

  localparam int CW = 16;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] LE_LAST   = CW'(LE_CYCLES - 1);
  localparam logic [4:0]    MSB_IDX   = 5'(WORD_WIDTH - 1);

  sh_phase_t             phase_q, phase_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [4:0]            bit_q, bit_d;
  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic                  sclk_q, sclk_d;
  logic                  data_q, data_d;
  logic                  le_q, le_d;
  logic                  done_q, done_d;

  // Next-state logic: bit timing, latch pulse and word load.
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    word_d  = word_q;
    sclk_d  = sclk_q;
    data_d  = data_q;
    le_d    = le_q;

    case (phase_q)
      SH_SHIFT: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == HALF_LAST) begin
          sclk_d = 1'b1;
        end
        if (cnt_q == BIT_LAST) begin
          cnt_d  = '0;
          sclk_d = 1'b0;
          if (bit_q == '0) begin
            phase_d = SH_LATCH;
            le_d    = 1'b1;
          end else begin
            bit_d  = bit_q - 5'd1;
            data_d = word_q[bit_d];
          end
        end
      end
      SH_LATCH: begin
        // data keeps the last bit while le is high
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == LE_LAST) begin
          cnt_d   = '0;
          le_d    = 1'b0;
          data_d  = 1'b0;
          phase_d = SH_IDLE;
        end
      end
      default: ;
    endcase

    // A new word may be loaded right out of the last latch cycle
    if (start) begin
      phase_d = SH_SHIFT;
      cnt_d   = '0;
      bit_d   = MSB_IDX;
      word_d  = word;
      data_d  = word[WORD_WIDTH-1];
      sclk_d  = 1'b0;
      le_d    = 1'b0;
    end

    done_d = (phase_d == SH_LATCH) && (cnt_d == LE_LAST);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= SH_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      word_q  <= '0;
      sclk_q  <= 1'b0;
      data_q  <= 1'b0;
      le_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      sclk_q  <= sclk_d;
      data_q  <= data_d;
      le_q    <= le_d;
      done_q  <= done_d;
    end
  end

  assign sclk      = sclk_q;
  assign data      = data_q;
  assign le        = le_q;
  assign word_done = done_q;
  assign shift_end = (phase_q == SH_SHIFT) && (cnt_q == BIT_LAST) && (bit_q == '0);

endmodule

// File: rtl/adf4158_cfg.sv
// ADF4158 power-up configuration sequencer: raises CE, waits, loads the eleven
// register words (R7 down to R0, R0 repeated last) and then holds config_done.
// Optional macro ADF4158_LOCK_WAIT_EN: after the last word, wait for MUXOUT to
// read 1 on 8 consecutive cycles before raising config_done.
module adf4158_cfg
  import adf4158_pkg::*;
#(
  parameter int          CLK_DIV   = 2,
  parameter int          CE_DELAY  = 16,
  parameter int          LE_CYCLES = 4,
  parameter logic [31:0] R0_WORD   = 32'h8024_B800,
  parameter logic [31:0] R1_WORD   = 32'h0000_0001,
  parameter logic [31:0] R2_WORD   = 32'h0040_8012,
  parameter logic [31:0] R3_WORD   = 32'h0000_0043,
  parameter logic [31:0] R4_WORD   = 32'h0018_0104,
  parameter logic [31:0] R5A_WORD  = 32'h0000_0005,
  parameter logic [31:0] R5B_WORD  = 32'h0080_0005,
  parameter logic [31:0] R6A_WORD  = 32'h0000_0006,
  parameter logic [31:0] R6B_WORD  = 32'h0080_0006,
  parameter logic [31:0] R7_WORD   = 32'h0000_0007
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic muxout,
  output logic ce,
  output logic sclk,
  output logic data,
  output logic le,
  output logic txdata,
  output logic config_done
);

  localparam logic [15:0]      CE_LAST  = 16'(CE_DELAY - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WORDS - 1);

  state_t                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  ce_q, ce_d;
  logic                  done_q, done_d;
  logic                  start;
  logic                  shift_end;
  logic                  word_done;
  logic [WORD_WIDTH-1:0] word_rom [NUM_WORDS];
  logic [WORD_WIDTH-1:0] start_word;

  // Load order: R7, R6 (step sel 0/1), R5 (dev sel 0/1), R4..R1, R0, R0 again.
  assign word_rom[0]  = with_ctrl(R7_WORD,  CTRL_R7);
  assign word_rom[1]  = with_ctrl(R6A_WORD, CTRL_R6);
  assign word_rom[2]  = with_ctrl(R6B_WORD, CTRL_R6);
  assign word_rom[3]  = with_ctrl(R5A_WORD, CTRL_R5);
  assign word_rom[4]  = with_ctrl(R5B_WORD, CTRL_R5);
  assign word_rom[5]  = with_ctrl(R4_WORD,  CTRL_R4);
  assign word_rom[6]  = with_ctrl(R3_WORD,  CTRL_R3);
  assign word_rom[7]  = with_ctrl(R2_WORD,  CTRL_R2);
  assign word_rom[8]  = with_ctrl(R1_WORD,  CTRL_R1);
  assign word_rom[9]  = with_ctrl(R0_WORD,  CTRL_R0);
  assign word_rom[10] = with_ctrl(R0_WORD,  CTRL_R0);

  assign start_word = word_rom[idx_d];

`ifdef ADF4158_LOCK_WAIT_EN
  logic [2:0] lock_cnt_q, lock_cnt_d;
`else
  logic unused_muxout;
  assign unused_muxout = muxout;
`endif

  // Sequencer next-state: power-up delay, word stepping and completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    ce_d    = ce_q;
    done_d  = done_q;
    start   = 1'b0;
`ifdef ADF4158_LOCK_WAIT_EN
    lock_cnt_d = lock_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = CE_WAIT;
          ce_d    = 1'b1;
          cnt_d   = '0;
        end
      end
      CE_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == CE_LAST) begin
          state_d = SHIFT;
          idx_d   = '0;
          start   = 1'b1;
        end
      end
      SHIFT: begin
        if (shift_end) begin
          state_d = LATCH;
        end
      end
      LATCH: begin
        if (word_done) begin
          if (idx_q != IDX_LAST) begin
            idx_d   = idx_q + 4'd1;
            start   = 1'b1;
            state_d = SHIFT;
          end else begin
`ifdef ADF4158_LOCK_WAIT_EN
            state_d    = LOCK_WAIT;
            lock_cnt_d = '0;
`else
            state_d = DONE;
            done_d  = 1'b1;
`endif
          end
        end
      end
`ifdef ADF4158_LOCK_WAIT_EN
      LOCK_WAIT: begin
        // any low sample restarts the run of consecutive highs
        if (muxout) begin
          if (lock_cnt_q == 3'd7) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            lock_cnt_d = lock_cnt_q + 3'd1;
          end
        end else begin
          lock_cnt_d = '0;
        end
      end
`endif
      DONE: ;
      default: state_d = IDLE;
    endcase
  end

  // Sequencer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      ce_q    <= 1'b0;
      done_q  <= 1'b0;
`ifdef ADF4158_LOCK_WAIT_EN
      lock_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ce_q    <= ce_d;
      done_q  <= done_d;
`ifdef ADF4158_LOCK_WAIT_EN
      lock_cnt_q <= lock_cnt_d;
`endif
    end
  end

  adf4158_shifter #(
    .CLK_DIV  (CLK_DIV),
    .LE_CYCLES(LE_CYCLES)
  ) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .word     (start_word),
    .sclk     (sclk),
    .data     (data),
    .le       (le),
    .shift_end(shift_end),
    .word_done(word_done)
  );

  assign ce          = ce_q;
  assign config_done = done_q;
  assign txdata      = 1'b0;

endmodule

// File: tb/tb_adf4158_cfg.sv
// Bench for adf4158_cfg: decodes the 3-wire bus into words and checks them,
// plus protocol timing, against values derived from the register map.
module tb_adf4158_cfg;

  localparam int CE_DELAY   = 16;
  localparam int CLK_DIV    = 2;
  localparam int LE_CYCLES  = 4;
  localparam int SEQ_CYCLES = CE_DELAY + 11 * (32 * CLK_DIV + LE_CYCLES);
`ifdef ADF4158_LOCK_WAIT_EN
  localparam int DONE_AT = 815;
`else
  localparam int DONE_AT = SEQ_CYCLES;
`endif

  logic clk = 1'b0;
  logic rst, enable, muxout;
  logic ce, sclk, data, le, txdata, config_done;

  always #5 clk = ~clk;

  adf4158_cfg dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .muxout     (muxout),
    .ce         (ce),
    .sclk       (sclk),
    .data       (data),
    .le         (le),
    .txdata     (txdata),
    .config_done(config_done)
  );

  logic [31:0] exp_words [11] = '{32'h0000_0007, 32'h0000_0006, 32'h0080_0006,
                                  32'h0000_0005, 32'h0080_0005, 32'h0018_0104,
                                  32'h0000_0043, 32'h0040_8012, 32'h0000_0001,
                                  32'h8024_B800, 32'h8024_B800};

  int n_asserts = 0;
  int n_fail    = 0;

  // observation results of one run
  int          c, rises, first_rise, done_at, viol, le_bad, nbits, le_len;
  logic [31:0] cap[$];
  logic [31:0] sh;
  logic        prev_sclk, prev_data, prev_le;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Watch the bus one cycle at a time; c=0 is the first sample after enable is taken.
  task automatic observe(input int abort_c, input int drop_c);
    c = -1; rises = 0; first_rise = -1; done_at = -1; viol = 0; le_bad = 0;
    nbits = 0; le_len = 0; sh = '0; cap.delete();
    prev_sclk = sclk; prev_data = data; prev_le = le;
    for (int k = 0; k < 1200; k++) begin
      @(negedge clk);
      c++;
      if (c == 0) check("ce_next_cycle", ce, 1);
      if (!ce || txdata) viol++;
      if (le && sclk) viol++;
      if (sclk && prev_sclk && data !== prev_data) viol++;
      if (sclk && !prev_sclk) begin
        rises++;
        if (first_rise < 0) first_rise = c;
        if (data !== prev_data) viol++;
        sh = {sh[30:0], data};
        nbits++;
      end
      if (le) le_len++;
      if (!le && prev_le) begin
        if (le_len != LE_CYCLES || nbits != 32) le_bad++;
        cap.push_back(sh);
        nbits = 0;
        le_len = 0;
      end
      if (config_done && done_at < 0) done_at = c;
      if (done_at >= 0 && (sclk || le || data || !config_done)) viol++;
      prev_sclk = sclk; prev_data = data; prev_le = le;
      if (c == drop_c) enable = 1'b0;
      muxout = ((c >= 799 && c <= 805) || c >= 807);
      if (c == abort_c) break;
      if (done_at >= 0 && c >= done_at + 3) break;
    end
  endtask

  task automatic check_full_run(input string tag);
    check({tag, "_word_count"}, cap.size(), 11);
    for (int i = 0; i < 11; i++) begin
      check($sformatf("%s_word%0d", tag, i),
            (i < cap.size()) ? {32'd0, cap[i]} : 64'hBAD0_0000_0000_0000, exp_words[i]);
    end
    check({tag, "_sclk_rises"}, rises, 352);
    check({tag, "_first_rise"}, first_rise, CE_DELAY + 1);
    check({tag, "_done_cycle"}, done_at, DONE_AT);
    check({tag, "_protocol_viol"}, viol, 0);
    check({tag, "_le_pulses"}, le_bad, 0);
    $display("run %s: words=%0d rises=%0d first_rise=%0d done_at=%0d", tag, cap.size(),
             rises, first_rise, done_at);
  endtask

  initial begin
    int idle, abort_c;
    rst = 1'b1; enable = 1'b1; muxout = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("reset_outputs", {ce, sclk, data, le, txdata, config_done}, 0);
    end

    // released with enable low for a random idle time: nothing must start
    rst = 1'b0; enable = 1'b0;
    idle = $urandom_range(2, 12);
    repeat (idle) begin
      @(negedge clk);
      check("idle_no_ce", {ce, sclk, le, config_done}, 0);
    end
    enable = 1'b1;
    observe(-1, $urandom_range(1, 700));
    check_full_run("run1");

    // DONE is sticky and enable has no effect
    enable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("done_sticky", {ce, config_done, sclk, le, data}, 5'b11000);
    end

    // fresh start, then reset in the middle of word 5
    rst = 1'b1; muxout = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("reset_after_done", {ce, sclk, data, le, config_done}, 0);
    end
    rst = 1'b0; enable = 1'b1;
    abort_c = CE_DELAY + 5 * (32 * CLK_DIV + LE_CYCLES) + $urandom_range(0, 67);
    observe(abort_c, -1);
    check("abort_words_before", cap.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("abort_word%0d", i),
            (i < cap.size()) ? {32'd0, cap[i]} : 64'hBAD0_0000_0000_0000, exp_words[i]);
    end
    $display("abort at cycle %0d after %0d words", abort_c, cap.size());
    rst = 1'b1; muxout = 1'b0;
    repeat ($urandom_range(1, 3)) begin
      @(negedge clk);
      check("reset_mid_word", {ce, sclk, data, le, config_done}, 0);
    end
    rst = 1'b0; enable = 1'b1;
    observe(-1, $urandom_range(1, 700));
    check_full_run("restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
